variant_sequencer: RTL and testbench
====================================

# variant_sequencer

Stimulus-side sequencer that feeds a match stage: it walks an 8-bit enum tag through every variant code 0..NUM_VARIANTS-1 and presents each one for a fixed number of accepted cycles. The downstream stage consumes the tag on its `_i_test_case` input and produces its result on `__output`. The sequencer runs once per start pulse, or continuously in loop mode, and reports completed passes.

## Interface
Parameters:
- `NUM_VARIANTS`, 3: number of variant codes emitted per pass; legal range 1..255.
- `HOLD_CYCLES`, 1: accepted cycles each variant is held; legal range 1..255.

Ports:
- `_i_clk`  in  1  clock; all state updates on the rising edge.
- `_i_rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `_i_clk`.
- `_i_start`  in  1  begin a pass; honoured only in IDLE.
- `_i_loop`  in  1  when high at the end of a pass, wrap to variant 0 instead of finishing.
- `_i_ready`  in  1  downstream accepts the current variant this cycle.
- `_o_variant`  out  8  current variant code; drives the match stage's `_i_test_case`.
- `_o_valid`  out  1  `_o_variant` is meaningful.
- `_o_done`  out  1  one-cycle pulse after the final beat of a non-looping pass.
- `_o_passes`  out  8  completed passes since reset; wraps 255->0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `_o_valid`=0 and `_o_variant`=0.
  - `_i_start`=1 loads variant=0 and hold=0, then goes to RUN.
- RUN: `_o_valid`=1.
  - A beat is accepted when `_o_valid && _i_ready`.
  - Each accepted beat increments the hold counter.
  - When hold reaches HOLD_CYCLES-1 on an accepted beat, the hold counter clears and the variant advances.
- End of pass: the final accepted beat of variant NUM_VARIANTS-1.
  - `_o_passes` increments.
  - If `_i_loop`=1 in that cycle, variant=0 and the sequencer stays in RUN.
  - Otherwise it goes to DONE.
- DONE: lasts exactly one cycle.
  - `_o_done`=1 and `_o_valid`=0.
  - Then returns to IDLE unconditionally.
- `_i_ready`=0 stalls. Variant, hold counter and state are frozen while stalled.
- `_i_start` in RUN or DONE is ignored; it is not queued.
- `_i_loop` is sampled only at the end-of-pass beat.
- Width rules:
  - The variant counter is 8 bits and never exceeds NUM_VARIANTS-1.
  - The hold counter is 8 bits.
  - `_o_passes` is modular 8-bit.
- NUM_VARIANTS=1 and HOLD_CYCLES=1: a single accepted beat ends the pass.

## Timing
- Reset (`_i_rst_n`=0 at an edge):
  - Next cycle: state IDLE, `_o_variant`=0, `_o_valid`=0, `_o_done`=0, `_o_passes`=0, hold=0.
  - Reset overrides start and any in-flight pass.
- Start latency: `_i_start` sampled at edge N gives `_o_valid`=1 and `_o_variant`=0 after edge N (one cycle).
- All outputs are registered; there is no combinational path from any input to any output.
- Variant advance: visible in the cycle after the accepted beat that completes the hold.
- Done: `_o_done` is high in the cycle after the end-of-pass beat, and `_o_passes` is updated in that same cycle.
- Earliest restart: IDLE is re-entered one cycle after DONE. A start pulse during DONE is lost.
- Full pass with `_i_ready` held high: NUM_VARIANTS×HOLD_CYCLES cycles of valid, plus one DONE cycle.

## Configuration
- `VARIANT_SEQ_REVERSE_EN`
  - Defined: each pass starts at NUM_VARIANTS-1 and decrements to 0. The end-of-pass beat is the final beat of variant 0. Loop wrap reloads NUM_VARIANTS-1.
  - Undefined: ascending order 0..NUM_VARIANTS-1 as described above.
  - Reset and IDLE values of `_o_variant` are 0 in both builds.

## Test plan
- Basic pass (defaults, ready=1): start pulse -> `_o_variant` = 0,1,2 on consecutive cycles with valid=1; then `_o_done`=1 for one cycle, `_o_passes`=1; match-stage `__output` reads 0,2,3.
- Hold and stall (HOLD_CYCLES=2): ready pattern 1,0,1,1,1,1 -> variant sequence 0,0,0,1,1,2 (the stall freezes variant 0); valid stays high throughout.
- Loop (NUM_VARIANTS=3, loop=1): 9 cycles -> variants 0,1,2,0,1,2,0,1,2; `_o_passes`=3; `_o_done` never asserted.
- Ignored start: pulse `_i_start` while variant=1 in RUN -> sequence unaffected; exactly one `_o_done` pulse at the end of the pass.
- Mid-pass reset: drive `_i_rst_n`=0 at variant=2 -> next cycle valid=0, variant=0, passes=0; a fresh start restarts from variant 0.
- Reverse build (`VARIANT_SEQ_REVERSE_EN`, defaults): start -> variants 2,1,0, then done; `__output` reads 3,2,0.

Source files
------------

// File: rtl/variant_sequencer.sv
// Walks an 8-bit variant tag through 0..NUM_VARIANTS-1, holding each for HOLD_CYCLES accepted beats.
// Define VARIANT_SEQ_REVERSE_EN to walk NUM_VARIANTS-1 down to 0 instead.
module variant_sequencer #(
    parameter int unsigned NUM_VARIANTS = 3,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic       _i_clk,
    input  logic       _i_rst_n,
    input  logic       _i_start,
    input  logic       _i_loop,
    input  logic       _i_ready,
    output logic [7:0] _o_variant,
    output logic       _o_valid,
    output logic       _o_done,
    output logic [7:0] _o_passes
);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } state_t;

    localparam logic [7:0] hold_last = 8'(HOLD_CYCLES - 1);

`ifdef VARIANT_SEQ_REVERSE_EN
    localparam logic [7:0] first_variant = 8'(NUM_VARIANTS - 1);
    localparam logic [7:0] last_variant  = 8'd0;
`else
    localparam logic [7:0] first_variant = 8'd0;
    localparam logic [7:0] last_variant  = 8'(NUM_VARIANTS - 1);
`endif

    state_t     state_q;
    logic [7:0] variant_q;
    logic [7:0] hold_q;
    logic [7:0] passes_q;
    logic       valid_q;
    logic       done_q;

    always_ff @(posedge _i_clk) begin
        if (!_i_rst_n) begin
            state_q   <= st_idle;
            variant_q <= 8'd0;
            hold_q    <= 8'd0;
            passes_q  <= 8'd0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                st_idle: begin
                    done_q    <= 1'b0;
                    valid_q   <= 1'b0;
                    variant_q <= 8'd0;
                    if (_i_start) begin
                        state_q   <= st_run;
                        variant_q <= first_variant;
                        hold_q    <= 8'd0;
                        valid_q   <= 1'b1;
                    end
                end
                st_run: begin
                    // Everything is frozen while the downstream stalls.
                    if (_i_ready) begin
                        if (hold_q == hold_last) begin
                            hold_q <= 8'd0;
                            if (variant_q == last_variant) begin
                                passes_q <= passes_q + 8'd1;
                                if (_i_loop) begin
                                    variant_q <= first_variant;
                                end else begin
                                    state_q   <= st_done;
                                    variant_q <= 8'd0;
                                    valid_q   <= 1'b0;
                                    done_q    <= 1'b1;
                                end
                            end else begin
`ifdef VARIANT_SEQ_REVERSE_EN
                                variant_q <= variant_q - 8'd1;
`else
                                variant_q <= variant_q + 8'd1;
`endif
                            end
                        end else begin
                            hold_q <= hold_q + 8'd1;
                        end
                    end
                end
                st_done: begin
                    state_q <= st_idle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q   <= st_idle;
                    variant_q <= 8'd0;
                    hold_q    <= 8'd0;
                    valid_q   <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign _o_variant = variant_q;
    assign _o_valid   = valid_q;
    assign _o_done    = done_q;
    assign _o_passes  = passes_q;

endmodule

// File: tb/tb_variant_sequencer.sv
// Bench for variant_sequencer: two instances (default and multi-hold) against a beat-count model.
module tb_variant_sequencer;

    localparam int NV0 = 3;
    localparam int HC0 = 1;
    localparam int NV1 = 4;
    localparam int HC1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic loop = 1'b0;
    logic ready = 1'b0;

    logic [7:0] variant0, variant1, passes0, passes1;
    logic       valid0, valid1, done0, done1;

    int checks = 0;
    int errors = 0;

    // Model state: running flag, beats accepted in this pass, done-cycle flag, pass count.
    int m_run[2];
    int m_k[2];
    int m_done[2];
    int m_passes[2];
    int nv[2];
    int hc[2];

    always #5 clk = ~clk;

    variant_sequencer #(.NUM_VARIANTS(NV0), .HOLD_CYCLES(HC0)) u_dut0 (
        ._i_clk(clk), ._i_rst_n(rst_n), ._i_start(start), ._i_loop(loop), ._i_ready(ready),
        ._o_variant(variant0), ._o_valid(valid0), ._o_done(done0), ._o_passes(passes0)
    );

    variant_sequencer #(.NUM_VARIANTS(NV1), .HOLD_CYCLES(HC1)) u_dut1 (
        ._i_clk(clk), ._i_rst_n(rst_n), ._i_start(start), ._i_loop(loop), ._i_ready(ready),
        ._o_variant(variant1), ._o_valid(valid1), ._o_done(done1), ._o_passes(passes1)
    );

    function automatic int exp_variant(int i);
        int idx;
        if (m_run[i] == 0) return 0;
        idx = m_k[i] / hc[i];
`ifdef VARIANT_SEQ_REVERSE_EN
        return nv[i] - 1 - idx;
`else
        return idx;
`endif
    endfunction

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_run[i] = 0; m_k[i] = 0; m_done[i] = 0; m_passes[i] = 0;
            end else if (m_done[i] != 0) begin
                m_done[i] = 0;
            end else if (m_run[i] == 0) begin
                if (start) begin
                    m_run[i] = 1;
                    m_k[i] = 0;
                end
            end else if (ready) begin
                m_k[i] = m_k[i] + 1;
                if (m_k[i] == nv[i] * hc[i]) begin
                    m_k[i] = 0;
                    m_passes[i] = (m_passes[i] + 1) % 256;
                    if (!loop) begin
                        m_run[i] = 0;
                        m_done[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("variant0", variant0, 8'(exp_variant(0)));
        check("valid0", {7'd0, valid0}, 8'(m_run[0]));
        check("done0", {7'd0, done0}, 8'(m_done[0]));
        check("passes0", passes0, 8'(m_passes[0]));
        check("variant1", variant1, 8'(exp_variant(1)));
        check("valid1", {7'd0, valid1}, 8'(m_run[1]));
        check("done1", {7'd0, done1}, 8'(m_done[1]));
        check("passes1", passes1, 8'(m_passes[1]));
    endtask

    task automatic step(input logic r, input logic s, input logic l, input logic rd);
        rst_n = r; start = s; loop = l; ready = rd;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        nv[0] = NV0; hc[0] = HC0; nv[1] = NV1; hc[1] = HC1;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_k[i] = 0; m_done[i] = 0; m_passes[i] = 0;
        end

        // Reset state.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Basic pass, ready high, through done and back to idle.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

        // Stall pattern 1,0,1,1,1,1 repeated.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b0, (i % 6) != 0);

        // Loop mode, with a start pulse in RUN that must be ignored.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b1, i == 1, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

        // Start during DONE is lost.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, done1 | done0, 1'b0, 1'b1);

        // Mid-pass reset, then a fresh start.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 7));
        end

        // Long loop run to wrap the pass counter past 255.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3200; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
